// File: rtl/bcd_seg_pkg.sv
// Shared definitions for the 4-digit multiplexed BCD 7-segment display.
//   scan_state_t : scan FSM states (BLANK = all anodes off, DRIVE = one digit lit)
//   SEG_*        : active-low segment patterns, bit order {g,f,e,d,c,b,a}
//   AN_OFF       : all anodes off (active-low)
//   is_bcd       : true when a nibble is a legal BCD digit (0-9)
//   anode_sel    : active-low one-cold anode vector for a digit index
package bcd_seg_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_OFF    = 4'b1111;

    function automatic logic is_bcd(input logic [3:0] v);
        return (v <= 4'd9);
    endfunction

    function automatic logic [3:0] anode_sel(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder.
//   digit : 4-bit value; 0-9 decode to numerals, 10-15 decode to "E"
//   seg   : active-low segments {g,f,e,d,c,b,a}
module bcd_to_seg7
    import bcd_seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_E;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_E;
        endcase
    end

endmodule

// File: rtl/bcd_seg_scan4.sv
// Four-digit multiplexed 7-segment driver for the output of a 4-digit BCD adder.
// Each digit is lit for CLK_DIV cycles, separated by BLANK_CYC cycles with all
// anodes off to avoid ghosting. New adder results are captured on in_valid into
// holding registers and only reach the display at the start of a DRIVE phase.
// Optional feature: define SEG_LZB_EN for leading-zero blanking.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   in_valid : capture strobe for d1..d4 and co
//   d1..d4   : BCD digits, d1 least significant
//   co       : decimal carry-out, shown on the decimal point of digit 4
//   an       : active-low anodes, an[k] selects digit d(k+1)
//   seg      : active-low segments {g,f,e,d,c,b,a}
//   dp       : active-low decimal point (overflow indicator)
//   bcd_err  : sticky flag, a captured digit was greater than 9
module bcd_seg_scan4
    import bcd_seg_pkg::*;
#(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] d4,
    input  logic       co,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       bcd_err
);

    localparam int CNT_MAX = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(CLK_DIV - 1);

    scan_state_t      state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [1:0]       idx, idx_next;
    logic             load_disp;

    logic [3:0][3:0]  hold_dig;
    logic             hold_co;
    logic [3:0][3:0]  disp_dig;
    logic             disp_co;

    logic [3:0]       cur_digit;
    logic [6:0]       cur_seg;
    logic             suppress;
    logic             any_bad;

    logic [3:0]       an_next;
    logic [6:0]       seg_next;
    logic             dp_next;

    // Scan FSM: state, phase counter and digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_BLANK;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + 1'b1;
        idx_next   = idx;
        load_disp  = 1'b0;
        case (state)
            ST_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_next = ST_DRIVE;
                    cnt_next   = '0;
                    load_disp  = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (cnt == DRIVE_LAST) begin
                    state_next = ST_BLANK;
                    cnt_next   = '0;
                    idx_next   = idx + 2'd1;
                end
            end
            default: begin
                state_next = ST_BLANK;
                cnt_next   = '0;
            end
        endcase
    end

    assign any_bad = !is_bcd(d1) || !is_bcd(d2) || !is_bcd(d3) || !is_bcd(d4);

    // Holding registers follow in_valid; the display copy is taken only when a
    // DRIVE phase begins (using the pre-capture holding value on that edge), so
    // a lit digit never changes pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_dig <= '0;
            hold_co  <= 1'b0;
            disp_dig <= '0;
            disp_co  <= 1'b0;
            bcd_err  <= 1'b0;
        end else begin
            if (load_disp) begin
                disp_dig <= hold_dig;
                disp_co  <= hold_co;
            end
            if (in_valid) begin
                hold_dig <= {d4, d3, d2, d1};
                hold_co  <= co;
                if (any_bad) begin
                    bcd_err <= 1'b1;
                end
            end
        end
    end

    assign cur_digit = disp_dig[idx];

    bcd_to_seg7 u_dec (
        .digit (cur_digit),
        .seg   (cur_seg)
    );

`ifdef SEG_LZB_EN
    // zero_from[k]: digit k and every more significant digit are zero.
    // Index 0 is never blanked so a zero result still shows "0".
    logic [3:0] zero_from;

    always_comb begin
        zero_from    = '0;
        zero_from[3] = (disp_dig[3] == 4'd0);
        zero_from[2] = zero_from[3] && (disp_dig[2] == 4'd0);
        zero_from[1] = zero_from[2] && (disp_dig[1] == 4'd0);
        zero_from[0] = 1'b0;
    end

    assign suppress = zero_from[idx];
`else
    assign suppress = 1'b0;
`endif

    always_comb begin
        an_next  = AN_OFF;
        seg_next = SEG_BLANK;
        dp_next  = 1'b1;
        if (state == ST_DRIVE) begin
            if (!suppress) begin
                an_next  = anode_sel(idx);
                seg_next = cur_seg;
            end
            dp_next = !((idx == 2'd3) && disp_co);
        end
    end

    // Registered outputs: they show the FSM state one cycle after it changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_bcd_seg_scan4.sv
// Bench for bcd_seg_scan4 with CLK_DIV=4, BLANK_CYC=2. The reference model
// tracks time since reset as a cycle count and derives the displayed digit
// from the scan period arithmetic.
module tb_bcd_seg_scan4;

    localparam int CD = 4;
    localparam int BC = 2;
    localparam int PH = CD + BC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] d1 = '0, d2 = '0, d3 = '0, d4 = '0;
    logic       co = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       bcd_err;

    always #5 clk = ~clk;

    bcd_seg_scan4 #(.CLK_DIV(CD), .BLANK_CYC(BC)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .d1       (d1),
        .d2       (d2),
        .d3       (d3),
        .d4       (d4),
        .co       (co),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .bcd_err  (bcd_err)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference state: cycles since reset edge, latched value, displayed value.
    int         t;
    logic [3:0] m_hold [4];
    logic       m_hold_co;
    logic [3:0] m_disp [4];
    logic       m_disp_co;
    logic       m_err;
    logic [11:0] m_out;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0000110;
        endcase
    endfunction

    // Display {an,seg,dp} for the scan position t cycles after reset.
    function automatic logic [11:0] scan_view();
        int         pos;
        int         k;
        logic [3:0] a;
        logic [6:0] s;
        logic       d;
        logic       hide;
        pos = t % PH;
        k   = (t / PH) % 4;
        if (pos < BC) return {4'b1111, 7'b1111111, 1'b1};
        a = 4'b1111;
        a[k] = 1'b0;
        s = seg_of(m_disp[k]);
        d = !(k == 3 && m_disp_co);
        hide = 1'b0;
`ifdef SEG_LZB_EN
        if (k >= 1) begin
            hide = 1'b1;
            for (int i = k; i < 4; i++) if (m_disp[i] != 4'd0) hide = 1'b0;
        end
`endif
        if (hide) begin
            a = 4'b1111;
            s = 7'b1111111;
        end
        return {a, s, d};
    endfunction

    task automatic cyc(input logic r, input logic v,
                       input logic [3:0] a4, input logic [3:0] a3,
                       input logic [3:0] a2, input logic [3:0] a1,
                       input logic c);
        rst = r; in_valid = v; d4 = a4; d3 = a3; d2 = a2; d1 = a1; co = c;
        @(posedge clk);
        if (r) begin
            m_out = {4'b1111, 7'b1111111, 1'b1};
            t = 0;
            for (int i = 0; i < 4; i++) begin m_hold[i] = '0; m_disp[i] = '0; end
            m_hold_co = 1'b0; m_disp_co = 1'b0; m_err = 1'b0;
        end else begin
            m_out = scan_view();
            t++;
            if (t % PH == BC) begin
                for (int i = 0; i < 4; i++) m_disp[i] = m_hold[i];
                m_disp_co = m_hold_co;
            end
            if (v) begin
                m_hold[0] = a1; m_hold[1] = a2; m_hold[2] = a3; m_hold[3] = a4;
                m_hold_co = c;
                if (a1 > 9 || a2 > 9 || a3 > 9 || a4 > 9) m_err = 1'b1;
            end
        end
        #1;
        vectors++;
        assert ({an, seg, dp, bcd_err} === {m_out, m_err})
        else begin
            miscompares++;
            $error("FAIL scan t=%0d observed an=%b seg=%b dp=%b err=%b expected an=%b seg=%b dp=%b err=%b",
                   t, an, seg, dp, bcd_err, m_out[11:8], m_out[7:1], m_out[0], m_err);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        int lit0;
        int dark;
        #1;
        // Reset, then a 1,2,3,4 capture and one full scan period.
        cyc(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        cyc(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        cyc(1'b0, 1'b1, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
        idle(24);
        lit0 = 0;
        dark = 0;
        for (int i = 0; i < 24; i++) begin
            idle(1);
            if (an == 4'b1110) lit0++;
            if (an == 4'b1111) dark++;
        end
        vectors++;
        assert (lit0 == CD && dark == 4 * BC)
        else begin
            miscompares++;
            $error("FAIL period observed lit0=%0d dark=%0d expected lit0=%0d dark=%0d",
                   lit0, dark, CD, 4 * BC);
        end

        // All nines with carry: dp only on the most significant digit.
        cyc(1'b0, 1'b1, 4'd9, 4'd9, 4'd9, 4'd9, 1'b1);
        idle(50);

        // Captures landing in mid-DRIVE.
        for (int i = 0; i < 6; i++) begin
            idle(3 + i);
            cyc(1'b0, 1'b1, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
        end
        idle(30);

        // Leading zeros and an all-zero result.
        cyc(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd7, 1'b0);
        idle(30);
        cyc(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        idle(30);

        // Illegal digit: shows E, flag sticks through a clean capture.
        cyc(1'b0, 1'b1, 4'd0, 4'd0, 4'hC, 4'd0, 1'b0);
        idle(10);
        cyc(1'b0, 1'b1, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
        idle(30);
        vectors++;
        assert (bcd_err === 1'b1)
        else begin
            miscompares++;
            $error("FAIL err_sticky observed %b expected 1", bcd_err);
        end

        // Reset together with a capture, mid-scan.
        idle(3);
        cyc(1'b1, 1'b1, 4'd5, 4'd6, 4'd7, 4'd8, 1'b1);
        idle(30);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            logic [3:0] r4, r3, r2, r1;
            r4 = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            r3 = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
            r2 = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
            r1 = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0) r4 = 4'd0;
            cyc(($urandom_range(0, 149) == 0), ($urandom_range(0, 7) == 0),
                r4, r3, r2, r1, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bcd_seg_scan4.md
BCD_SEG_SCAN4 -- requirements
Module: bcd_seg_scan4

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000, clock cycles each digit is driven (DRIVE phase); legal range >= 2.
REQ-002 SHALL have parameter BLANK_CYC, default 16, clock cycles all anodes are off between digits (BLANK phase); legal range >= 1.
REQ-003 SHALL have port clk  in  1  sole clock; all logic is rising-edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  in  1  capture strobe for d1..d4 and co.
REQ-006 SHALL have ports d1, d2, d3, d4  in  4 each  BCD digits from the 4-digit BCD adder stage; d1 is least significant.
REQ-007 SHALL have port co  in  1  decimal carry-out from the adder stage.
REQ-008 SHALL have port an  out  4  digit anodes, active-low; an[k] selects digit d(k+1).
REQ-009 SHALL have port seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 SHALL have port dp  out  1  decimal point, active-low; used as the overflow indicator.
REQ-011 SHALL have port bcd_err  out  1  sticky flag: a captured digit was > 9.

Function
REQ-012 SHALL capture d1..d4 and co into holding registers on any rising edge with in_valid=1; with in_valid=0 the holding registers keep their values.
REQ-013 SHALL copy the holding registers into display registers only on the BLANK->DRIVE transition, so a digit's pattern never changes mid-DRIVE.
REQ-014 SHALL run a two-state FSM, BLANK and DRIVE: BLANK lasts BLANK_CYC cycles, then DRIVE; DRIVE lasts CLK_DIV cycles, then BLANK.
REQ-015 SHALL keep a 2-bit digit index that increments on each DRIVE->BLANK transition and wraps from 3 to 0; one full scan is 4*(CLK_DIV+BLANK_CYC) cycles.
REQ-016 SHALL, in BLANK, drive an=4'b1111, seg=7'b1111111 and dp=1.
REQ-017 SHALL, in DRIVE, drive an low only on the bit at the current index, and drive seg with the decoded display digit at that index.
REQ-018 SHALL decode digits 0-9 to the standard 7-segment patterns (0 -> 7'b1000000, 8 -> 7'b0000000) and values 10-15 to "E" (7'b0000110).
REQ-019 SHALL drive dp=0 only in DRIVE at index 3 with the displayed co=1; otherwise dp=1.
REQ-020 SHALL set bcd_err on any capture where any of d1..d4 is > 9, and clear it only on reset.
REQ-021 SHALL register all outputs; outputs reflect the FSM state one cycle after the state transition.

Reset
REQ-022 SHALL, on rst=1 at a rising edge, clear the holding and display registers, co latch, index, phase counter and bcd_err, and set the FSM to BLANK.
REQ-023 SHALL drive an=4'b1111, seg=7'b1111111, dp=1 and bcd_err=0 in the cycle after reset.
REQ-024 SHALL give rst priority over in_valid in the same cycle; the capture is discarded.
REQ-025 SHALL let reset asserted mid-DRIVE abort the scan immediately; after release, the first DRIVE is index 0, BLANK_CYC cycles later.

Configuration
REQ-026 SHALL support macro SEG_LZB_EN (leading-zero blanking).
REQ-027 SHALL, with SEG_LZB_EN defined, keep the anode off and seg=7'b1111111 during DRIVE for index k >= 1 when that digit and all higher digits are 0; index 0 always displays. The dp rule is unchanged.
REQ-028 SHALL, with SEG_LZB_EN undefined, display all four digits unconditionally.

Structure
REQ-029 SHALL place the segment pattern constants (0-9, E, blank) and the FSM state encoding in shared package bcd_seg_pkg.
REQ-030 SHALL use one combinational sub-module, bcd_to_seg7 (4-bit in, 7-bit active-low out), instantiated once on the muxed digit.

Verification (CLK_DIV=4, BLANK_CYC=2)
REQ-031 SHALL verify: reset, then capture d4..d1=1,2,3,4, co=0 -> the scan shows an=1110 with seg=digit 4, then 1101/3, 1011/2, 0111/1, each for 4 cycles separated by 2 cycles of an=1111; period is 24 cycles.
REQ-032 SHALL verify: capture 9,9,9,9 with co=1 -> dp=0 only during the an=0111 window; all seg show 9 (7'b0010000).
REQ-033 SHALL verify: in_valid pulses mid-DRIVE with new digits -> the current digit's pattern is unchanged until the next BLANK->DRIVE transition.
REQ-034 SHALL verify: capture d2=4'hC -> bcd_err=1 persists after a later valid capture; the digit shows E; only rst clears bcd_err.
REQ-035 SHALL verify: with SEG_LZB_EN, capture 0,0,0,7 -> only the an=1110 window is active and shows 7; capture 0,0,0,0 -> index 0 shows 0. Without the macro, all four digits show.
REQ-036 SHALL verify: rst asserted together with in_valid mid-scan -> outputs are blank the next cycle, bcd_err=0, and the first post-reset DRIVE is an=1110 showing 0.
